// File: rtl/timer_pkg.sv
// Shared state encodings and BCD constants for the stopwatch run-control stage.
package timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam logic [7:0] BCD_MAX   = 8'h99;
   localparam logic [7:0] BEST_INIT = 8'h99;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-FF synchronizer, N-sample agreement filter and
// a single-cycle rising-edge pulse of the debounced level.
module btn_debounce #(
   parameter int DEBOUNCE_LEN = 4
) (
   input  logic clk26,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic pulse
);

   logic [1:0]              sync_r;
   logic [DEBOUNCE_LEN-1:0] shift_r;
   logic                    level_r;
   logic                    level_d_r;

   // Synchronize, collect samples and update the filtered level.
   always_ff @(posedge clk26) begin
      if (reset) begin
         sync_r    <= 2'b00;
         shift_r   <= {DEBOUNCE_LEN{1'b0}};
         level_r   <= 1'b0;
         level_d_r <= 1'b0;
      end else begin
         sync_r    <= {sync_r[0], raw};
         shift_r   <= {shift_r[DEBOUNCE_LEN-2:0], sync_r[1]};
         // Level only moves on unanimous agreement; mixed windows hold it.
         if (&shift_r) begin
            level_r <= 1'b1;
         end else if (~|shift_r) begin
            level_r <= 1'b0;
         end else begin
            level_r <= level_r;
         end
         level_d_r <= level_r;
      end
   end

   assign level = level_r;
   assign pulse = level_r & ~level_d_r;

endmodule

// File: rtl/timer_ctrl.sv
// Run-control FSM for the BCD stopwatch: drives start, captures the elapsed
// time at the end of each run and tracks the best (lowest) time.
module timer_ctrl
   import timer_pkg::*;
#(
   parameter int DEBOUNCE_LEN = 4
) (
   input  logic       clk26,
   input  logic       reset,
   input  logic       btn_go,
   input  logic       btn_clr,
   input  logic [3:0] bcd1_in,
   input  logic [3:0] bcd0_in,
   output logic       start,
   output logic [3:0] last1,
   output logic [3:0] last0,
   output logic [3:0] best1,
   output logic [3:0] best0,
   output logic       best_valid,
   output logic       new_record,
   output logic [1:0] state
);

   logic       go_level_s, go_pulse_s;
   logic       clr_level_s, clr_pulse_s;
   logic [7:0] bcd_s;
   state_t     state_r;
   logic [7:0] last_r, best_r;
   logic       best_valid_r, new_record_r;

   btn_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_go (
      .clk26 (clk26),
      .reset (reset),
      .raw   (btn_go),
      .level (go_level_s),
      .pulse (go_pulse_s)
   );

   btn_debounce #(.DEBOUNCE_LEN(DEBOUNCE_LEN)) u_clr (
      .clk26 (clk26),
      .reset (reset),
      .raw   (btn_clr),
      .level (clr_level_s),
      .pulse (clr_pulse_s)
   );

   // Packed BCD compares correctly as unsigned since each digit is 0..9.
   assign bcd_s = {bcd1_in, bcd0_in};

   // Run-control FSM with capture and best-time tracking.
   always_ff @(posedge clk26) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         last_r       <= 8'h00;
         best_r       <= BEST_INIT;
         best_valid_r <= 1'b0;
         new_record_r <= 1'b0;
      end else begin
         new_record_r <= 1'b0;
         if (clr_pulse_s) begin
            state_r      <= ST_IDLE;
            last_r       <= 8'h00;
            best_r       <= BEST_INIT;
            best_valid_r <= 1'b0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (go_pulse_s) state_r <= ST_RUN;
                  else            state_r <= ST_IDLE;
               end
               ST_RUN: begin
                  // Saturating at 99 stops the run instead of letting the timer wrap.
                  if (go_pulse_s || (bcd_s == BCD_MAX)) begin
                     state_r <= ST_DONE;
                     last_r  <= bcd_s;
                     if (!best_valid_r || (bcd_s < best_r)) begin
                        best_r       <= bcd_s;
                        best_valid_r <= 1'b1;
                        new_record_r <= 1'b1;
                     end
                  end else begin
                     state_r <= ST_RUN;
                  end
               end
               ST_DONE: begin
                  if (go_pulse_s) state_r <= ST_RUN;
                  else            state_r <= ST_DONE;
               end
               default: state_r <= ST_IDLE;
            endcase
         end
      end
   end

   assign start      = (state_r == ST_RUN);
   assign state      = state_r;
   assign last1      = last_r[7:4];
   assign last0      = last_r[3:0];
   assign best1      = best_r[7:4];
   assign best0      = best_r[3:0];
   assign best_valid = best_valid_r;
   assign new_record = new_record_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: debounce timing, glitch rejection, capture,
// best-time tracking, auto-stop, clear priority and reset mid-run.
module tb_timer_ctrl;

   logic       clk26;
   logic       reset;
   logic       btn_go;
   logic       btn_clr;
   logic [3:0] bcd1_in;
   logic [3:0] bcd0_in;
   logic       start;
   logic [3:0] last1, last0, best1, best0;
   logic       best_valid;
   logic       new_record;
   logic [1:0] state;

   int vectors = 0;
   int errors  = 0;
   int pulses  = 0;

   timer_ctrl #(.DEBOUNCE_LEN(4)) u_dut (
      .clk26      (clk26),
      .reset      (reset),
      .btn_go     (btn_go),
      .btn_clr    (btn_clr),
      .bcd1_in    (bcd1_in),
      .bcd0_in    (bcd0_in),
      .start      (start),
      .last1      (last1),
      .last0      (last0),
      .best1      (best1),
      .best0      (best0),
      .best_valid (best_valid),
      .new_record (new_record),
      .state      (state)
   );

   initial clk26 = 1'b0;
   always #5 clk26 = ~clk26;

   // Advance one clock edge and settle just past it.
   task automatic step();
      @(posedge clk26);
      #1;
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag, input logic [1:0] st, input logic st_start,
                            input logic [7:0] lst, input logic [7:0] bst,
                            input logic bv, input logic nr);
      check({tag, ".state"}, {6'd0, state}, {6'd0, st});
      check({tag, ".start"}, {7'd0, start}, {7'd0, st_start});
      check({tag, ".last"}, {last1, last0}, lst);
      check({tag, ".best"}, {best1, best0}, bst);
      check({tag, ".best_valid"}, {7'd0, best_valid}, {7'd0, bv});
      check({tag, ".new_record"}, {7'd0, new_record}, {7'd0, nr});
   endtask

   // Hold btn_go for edges 0..7: the FSM reacts on edge 7.
   task automatic press_go();
      btn_go = 1'b1;
      repeat (8) step();
   endtask

   task automatic release_btns();
      btn_go  = 1'b0;
      btn_clr = 1'b0;
      repeat (12) step();
   endtask

   task automatic set_bcd(input logic [7:0] v);
      bcd1_in = v[7:4];
      bcd0_in = v[3:0];
   endtask

   initial begin
      reset   = 1'b1;
      btn_go  = 1'b0;
      btn_clr = 1'b0;
      set_bcd(8'h00);
      repeat (3) step();
      reset = 1'b0;
      step();
      check_all("reset", 2'd0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0);

      // Glitches of 3 cycles never fill the 4-sample window.
      pulses = 0;
      for (int g = 0; g < 5; g++) begin
         btn_go = 1'b1;
         for (int c = 0; c < 3; c++) begin
            step();
            if (u_dut.go_pulse_s) pulses++;
         end
         btn_go = 1'b0;
         for (int c = 0; c < 10; c++) begin
            step();
            if (u_dut.go_pulse_s) pulses++;
         end
      end
      check("glitch.pulses", pulses[7:0], 8'd0);
      check("glitch.state", {6'd0, state}, 8'd0);
      check("glitch.start", {7'd0, start}, 8'd0);

      // Held press: pulse after edge 6, RUN after edge 7, one pulse over 20 cycles.
      pulses = 0;
      btn_go = 1'b1;
      repeat (6) step();
      check("hold.e5.pulse", {7'd0, u_dut.go_pulse_s}, 8'd0);
      step();
      check("hold.e6.pulse", {7'd0, u_dut.go_pulse_s}, 8'd1);
      check("hold.e6.state", {6'd0, state}, 8'd0);
      pulses = 1;
      step();
      check("hold.e7.state", {6'd0, state}, 8'd1);
      check("hold.e7.start", {7'd0, start}, 8'd1);
      for (int c = 8; c < 20; c++) begin
         step();
         if (u_dut.go_pulse_s) pulses++;
      end
      check("hold.pulses", pulses[7:0], 8'd1);
      check("hold.run", {6'd0, state}, 8'd1);
      release_btns();

      // First capture sets the record.
      set_bcd(8'h42);
      press_go();
      check_all("run1", 2'd2, 1'b0, 8'h42, 8'h42, 1'b1, 1'b1);
      step();
      check("run1.nr_drop", {7'd0, new_record}, 8'd0);
      release_btns();

      // Slower run keeps the old best.
      press_go();
      check("run2.start", {6'd0, state}, 8'd1);
      release_btns();
      set_bcd(8'h57);
      press_go();
      check_all("run2", 2'd2, 1'b0, 8'h57, 8'h42, 1'b1, 1'b0);
      release_btns();

      // Tie keeps the best and does not pulse.
      press_go();
      release_btns();
      set_bcd(8'h42);
      press_go();
      check_all("tie", 2'd2, 1'b0, 8'h42, 8'h42, 1'b1, 1'b0);
      release_btns();

      // Auto-stop at 99 without any button.
      set_bcd(8'h98);
      press_go();
      release_btns();
      check("auto.pre", {6'd0, state}, 8'd1);
      set_bcd(8'h99);
      step();
      check_all("auto", 2'd2, 1'b0, 8'h99, 8'h42, 1'b1, 1'b0);

      // Clear wins over a simultaneous go while running.
      set_bcd(8'h10);
      press_go();
      release_btns();
      check("both.pre", {6'd0, state}, 8'd1);
      btn_clr = 1'b1;
      press_go();
      check_all("both", 2'd0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0);
      release_btns();

      // Build best=30, start another run, then reset mid-run.
      set_bcd(8'h30);
      press_go();
      release_btns();
      press_go();
      check_all("best30", 2'd2, 1'b0, 8'h30, 8'h30, 1'b1, 1'b1);
      release_btns();
      press_go();
      release_btns();
      check("rst.pre", {6'd0, state}, 8'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check_all("rst", 2'd0, 1'b0, 8'h00, 8'h99, 1'b0, 1'b0);
      set_bcd(8'h05);
      press_go();
      check_all("restart", 2'd1, 1'b1, 8'h00, 8'h99, 1'b0, 1'b0);
      release_btns();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/timer_ctrl.md
Name: timer_ctrl

Overview:
Run-control stage directly upstream of the two-digit BCD stopwatch timer.
- Debounces two raw push buttons and drives the timer's level `start` input.
- Captures the elapsed BCD count when a run ends and keeps a best (lowest) time record for display.
- Runs entirely in the clk26 domain.

Parameters:
DEBOUNCE_LEN, 4, number of consecutive identical synchronized samples needed to change a debounced button level (legal 2..16)

Ports:
clk26  input  1  system clock; all state updates on posedge
reset  input  1  synchronous, active-high; clock clk26
btn_go  input  1  raw start/stop push button, asynchronous, active-high
btn_clr  input  1  raw clear push button, asynchronous, active-high
bcd1_in  input  4  timer tens digit (0..9)
bcd0_in  input  4  timer units digit (0..9)
start  output  1  level to timer; 1 exactly while state==RUN
last1  output  4  tens digit of most recent captured run
last0  output  4  units digit of most recent captured run
best1  output  4  tens digit of best (lowest) run
best0  output  4  units digit of best run
best_valid  output  1  1 once at least one run captured since reset/clear
new_record  output  1  one-cycle pulse when best is updated
state  output  2  current FSM state encoding (debug/LED)

Behaviour:
- Reset values (registered outputs): state=IDLE, start=0, last=8'h00, best=8'h99, best_valid=0, new_record=0. Debounce pipelines cleared; debounced levels = 0.
- Debounce, per button, identical logic:
  - 2-FF synchronizer, then DEBOUNCE_LEN-bit shift register.
  - Debounced level register sets when the shift register is all ones and clears when it is all zeros; otherwise it holds.
  - Pulse = debounced & ~debounced_d, exactly one cycle wide.
  - Counting the first edge that samples the raw input high as edge 0, the pulse is high in the cycle after edge DEBOUNCE_LEN+2, provided the input stays high.
  - A glitch shorter than DEBOUNCE_LEN+? samples never produces a pulse: any raw high run shorter than DEBOUNCE_LEN cycles yields no pulse.
  - Holding a button produces only one pulse. Release plus re-press is required for another.
- FSM states and encoding: IDLE=2'd0, RUN=2'd1, DONE=2'd2. Encoding 2'd3 is illegal and returns to IDLE.
  - IDLE: go_pulse -> RUN.
  - RUN: go_pulse -> DONE with capture. Packed {bcd1_in,bcd0_in}==8'h99 with no go_pulse -> DONE with capture of 8'h99 (auto-stop, no wrap).
  - DONE: go_pulse -> RUN (new run; last and best are retained).
  - Any state: clr_pulse -> IDLE. Also sets last=8'h00, best=8'h99, best_valid=0.
  - clr_pulse has priority over go_pulse in the same cycle.
- start is decoded from the state register: 1 in the cycle after the edge entering RUN, 0 in the cycle after the edge leaving it.
- Capture happens on the RUN->DONE edge: last <= {bcd1_in,bcd0_in} as sampled at that edge.
- Best-time update, on the same edge:
  - Comparison uses the packed 8-bit BCD value as an unsigned compare, which is valid because both digits are in 0..9.
  - If !best_valid or captured < best: best <= captured, best_valid <= 1, new_record high for the next cycle only.
  - A tie does not update best and does not pulse.
- A zero-length run (capture 8'h00) is a legal time.
- reset asserted mid-run: all outputs return to reset values at that edge, and start drops the next cycle.

Decomposition:
- Package timer_pkg:
  - state encodings ST_IDLE, ST_RUN, ST_DONE (2-bit).
  - BCD_MAX = 8'h99.
  - BEST_INIT = 8'h99.
- One sub-module, btn_debounce (params DEBOUNCE_LEN; ports clk26, reset, raw, level, pulse), instantiated twice: go and clr.
- FSM, capture and compare logic live in timer_ctrl.

Test Plan:
- DEBOUNCE_LEN=4, btn_go high at edge 0 and held 20 cycles -> exactly one go_pulse (cycle after edge 6); state 0->1 at edge 7; start=1 from cycle after edge 7.
- btn_go pulses high 3 cycles, low 10 cycles, repeated 5 times -> no go_pulse; state stays IDLE, start stays 0.
- IDLE -> RUN, bcd inputs driven 8'h42, go pressed -> state DONE, last=8'h42, best=8'h42, best_valid=1, new_record high one cycle. Second run captured at 8'h57 -> last=8'h57, best stays 8'h42, no new_record. Third run at 8'h42 (tie) -> no update.
- In RUN, bcd inputs reach 8'h99 with no button -> auto DONE next edge, last=8'h99, start falls.
- btn_go and btn_clr debounced pulses in the same cycle while in RUN -> state IDLE, best=8'h99, best_valid=0, last=8'h00, start=0.
- reset asserted for 1 cycle while in RUN with best=8'h30 -> all outputs at reset values after that edge; a subsequent btn_go press restarts normally.
